// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the clock divider bank.
package clock_divider_pkg;

  localparam int DIV_W_DEF = 8;

  typedef logic [DIV_W_DEF-1:0] div_t;

  typedef enum logic [1:0] {
    CH_STOP = 2'd0,
    CH_LOW  = 2'd1,
    CH_HIGH = 2'd2
  } ch_state_e;

  function automatic int chidx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One 50%-duty divider channel: half-period counter, output flop and pending ratio
// that is only applied on a falling edge (or immediately while stopped/gated low).
module clock_divider_channel #(
  parameter int               DIV_W     = 8,
  parameter logic [DIV_W-1:0] RESET_DIV = {DIV_W{1'b0}}
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic             run_en,
  output logic             clk_div,
  output logic             busy
);

  logic [DIV_W-1:0] act_r;
  logic [DIV_W-1:0] hcnt_r;
  logic [DIV_W-1:0] pend_r;
  logic             out_r;
  logic             pend_valid_r;
  logic             at_end;
  logic             active;

  assign at_end  = (hcnt_r == (act_r - DIV_W'(1)));
  // A gated channel that is high still finishes its high phase before stopping.
  assign active  = (act_r != {DIV_W{1'b0}}) && (run_en || out_r);
  assign clk_div = out_r;
  assign busy    = pend_valid_r;

  // Counter, output flop, pending capture and apply.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_r        <= RESET_DIV;
      hcnt_r       <= {DIV_W{1'b0}};
      pend_r       <= {DIV_W{1'b0}};
      out_r        <= 1'b0;
      pend_valid_r <= 1'b0;
    end else begin
      if (load) begin
        pend_r       <= load_div;
        pend_valid_r <= 1'b1;
      end
      if (active) begin
        if (at_end) begin
          out_r  <= ~out_r;
          hcnt_r <= {DIV_W{1'b0}};
          if (out_r && pend_valid_r) begin
            act_r        <= pend_r;
            pend_valid_r <= 1'b0;
          end
        end else begin
          hcnt_r <= hcnt_r + DIV_W'(1);
        end
      end else begin
        out_r  <= 1'b0;
        hcnt_r <= {DIV_W{1'b0}};
        if (pend_valid_r) begin
          act_r        <= pend_r;
          pend_valid_r <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH programmable 50%-duty clock dividers with a valid/ready config port.
// Optional per-channel run enable (gate_en) when CLKDIV_GATE_EN is defined.
module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [chidx_w(NUM_CH)-1:0]    cfg_ch,
  input  logic [DIV_W-1:0]              cfg_div,
  output logic [NUM_CH-1:0]             clock_out,
  output logic [NUM_CH-1:0]             busy
`ifdef CLKDIV_GATE_EN
  ,
  input  logic [NUM_CH-1:0]             gate_en
`endif
);

  localparam int CH_W = chidx_w(NUM_CH);

  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] run_en;

`ifdef CLKDIV_GATE_EN
  assign run_en = gate_en;
`else
  assign run_en = {NUM_CH{1'b1}};
`endif

  // Out-of-range channel indices stay ready and their requests are dropped.
  always_comb begin
    cfg_ready = 1'b1;
    load      = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~busy[i];
        load[i]   = cfg_valid & ~busy[i];
      end else begin
        load[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_divider_channel #(
      .DIV_W     (DIV_W),
      .RESET_DIV (DIV_W'(RESET_DIV))
    ) u_ch (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (load[g]),
      .load_div (cfg_div),
      .run_en   (run_en[g]),
      .clk_div  (clock_out[g]),
      .busy     (busy[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench: expected clock_out edges (channel, cycle, level) are queued by the
// stimulus; a negedge monitor pops and compares every observed edge.
module tb_clock_divider_bank;

  localparam int NCH = 3;
  localparam int B   = 8;
  localparam int C   = B + 40;
  localparam int D   = C + 35;
  localparam int E   = D + 25;

  logic           clock;
  logic           reset_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [7:0]     cfg_div;
  logic [NCH-1:0] clock_out;
  logic [NCH-1:0] busy;
`ifdef CLKDIV_GATE_EN
  logic [NCH-1:0] gate_en;
`endif

  typedef struct {
    int   ch;
    int   cyc;
    logic val;
  } ev_t;

  ev_t            evq[$];
  int             cyc = 0;
  int             compared = 0;
  int             failed = 0;
  logic [NCH-1:0] prev_out = '0;

  clock_divider_bank #(.NUM_CH(NCH), .DIV_W(8), .RESET_DIV(0)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .clock_out (clock_out),
`ifdef CLKDIV_GATE_EN
    .gate_en   (gate_en),
`endif
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input int c, input logic v);
    ev_t e;
    e.ch = ch; e.cyc = c; e.val = v;
    evq.push_back(e);
  endtask

  task automatic wait_neg();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) wait_neg();
  endtask

  task automatic cfg_write(input int ch, input int div, input logic exp_ready);
    cfg_ch    = ch[1:0];
    cfg_div   = div[7:0];
    cfg_valid = 1'b1;
    #1;
    check($sformatf("cfg_ready_wr_ch%0d", ch), {31'd0, cfg_ready}, {31'd0, exp_ready});
    wait_neg();
    cfg_valid = 1'b0;
  endtask

  task automatic probe_ready(input int ch, input logic exp_ready);
    cfg_ch = ch[1:0];
    #1;
    check($sformatf("cfg_ready_probe_ch%0d", ch), {31'd0, cfg_ready}, {31'd0, exp_ready});
  endtask

  // Edge monitor: every change on clock_out must match the oldest expectation of its channel.
  always @(negedge clock) begin
    int idx;
    for (int i = 0; i < NCH; i++) begin
      if (clock_out[i] !== prev_out[i]) begin
        idx = -1;
        for (int j = 0; j < evq.size(); j++)
          if (idx < 0 && evq[j].ch == i) idx = j;
        if (idx < 0) begin
          compared++;
          failed++;
          $display("FAIL unexpected_edge ch%0d: got level %0b at cycle %0d, expected no edge",
                   i, clock_out[i], cyc);
        end else begin
          check($sformatf("edge_cycle_ch%0d", i), cyc, evq[idx].cyc);
          check($sformatf("edge_level_ch%0d", i), {31'd0, clock_out[i]}, {31'd0, evq[idx].val});
          evq.delete(idx);
        end
      end
    end
    prev_out = clock_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd0;
`ifdef CLKDIV_GATE_EN
    gate_en   = '1;
`endif
    #2;
    check("reset_clock_out", {29'd0, clock_out}, 32'd0);
    check("reset_busy", {29'd0, busy}, 32'd0);
    check("reset_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(B);
    check("idle_clock_out", {29'd0, clock_out}, 32'd0);
    check("idle_busy", {29'd0, busy}, 32'd0);

    // ch0 stopped -> N=3
    push(0, B+5, 1'b1); push(0, B+8, 1'b0); push(0, B+11, 1'b1); push(0, B+14, 1'b0);
    cfg_write(0, 3, 1'b1);
    check("busy_after_accept", {29'd0, busy}, 32'd1);
    wait_cyc(B+2);
    check("busy_after_apply", {29'd0, busy}, 32'd0);

    // ch0 N=3 -> N=4 mid-high, then N=0 mid-high
    wait_cyc(B+12);
    push(0, B+18, 1'b1); push(0, B+22, 1'b0); push(0, B+26, 1'b1);
    cfg_write(0, 4, 1'b1);
    wait_cyc(B+27);
    push(0, B+30, 1'b0);
    cfg_write(0, 0, 1'b1);
    wait_cyc(B+29);
    probe_ready(0, 1'b0);
    wait_cyc(B+31);
    check("busy_after_stop", {29'd0, busy}, 32'd0);
    wait_cyc(B+32);
    cfg_write(3, 9, 1'b1);
    wait_cyc(B+34);
    check("dropped_busy", {29'd0, busy}, 32'd0);
    check("dropped_clock_out", {29'd0, clock_out}, 32'd0);

    // ch1 N=2 -> N=5 at first high cycle, then N=3 pending; ch2 written meanwhile
    wait_cyc(C);
    push(1, C+4, 1'b1); push(1, C+6, 1'b0); push(1, C+8, 1'b1);
    cfg_write(1, 2, 1'b1);
    wait_cyc(C+8);
    push(1, C+10, 1'b0); push(1, C+15, 1'b1);
    cfg_write(1, 5, 1'b1);
    wait_cyc(C+11);
    push(1, C+20, 1'b0); push(1, C+23, 1'b1);
    cfg_write(1, 3, 1'b1);
    wait_cyc(C+13);
    probe_ready(1, 1'b0);
    wait_cyc(C+14);
    push(2, C+17, 1'b1); push(2, C+18, 1'b0); push(2, C+19, 1'b1);
    push(2, C+20, 1'b0); push(2, C+21, 1'b1);
    cfg_write(2, 1, 1'b1);
    wait_cyc(C+19);
    probe_ready(1, 1'b0);
    wait_cyc(C+20);
    probe_ready(1, 1'b1);
    push(2, C+22, 1'b0);
    cfg_write(2, 0, 1'b1);
    wait_cyc(C+24);
    push(1, C+26, 1'b0);
    cfg_write(1, 0, 1'b1);

    // reset mid-high with a pending value
    wait_cyc(D);
    push(0, D+4, 1'b1); push(0, D+6, 1'b0); push(0, D+8, 1'b1);
    cfg_write(0, 2, 1'b1);
    wait_cyc(D+8);
    cfg_write(0, 7, 1'b1);
    check("busy_before_reset", {29'd0, busy}, 32'd1);
    push(0, D+10, 1'b0);
    reset_n = 1'b0;
    #1;
    check("async_reset_clock_out", {29'd0, clock_out}, 32'd0);
    check("async_reset_busy", {29'd0, busy}, 32'd0);
    wait_cyc(D+12);
    reset_n = 1'b1;
    #1;
    check("post_reset_busy", {29'd0, busy}, 32'd0);
    check("post_reset_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    wait_cyc(D+20);
    check("post_reset_stopped", {29'd0, clock_out}, 32'd0);

`ifdef CLKDIV_GATE_EN
    wait_cyc(E);
    push(0, E+5, 1'b1); push(0, E+8, 1'b0); push(0, E+11, 1'b1); push(0, E+14, 1'b0);
    cfg_write(0, 3, 1'b1);
    wait_cyc(E+12);
    gate_en[0] = 1'b0;
    wait_cyc(E+17);
    check("gated_low", {31'd0, clock_out[0]}, 32'd0);
    wait_cyc(E+20);
    push(0, E+23, 1'b1); push(0, E+26, 1'b0);
    gate_en[0] = 1'b1;
    wait_cyc(E+24);
    gate_en[0] = 1'b0;
    wait_cyc(E+35);
`else
    wait_cyc(E);
`endif

    check("pending_edges", evq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
